axis_elastic_buf: RTL and testbench

AXIS_ELASTIC_BUF -- requirements
Module: axis_elastic_buf

---
 rtl/axis_elastic_buf.sv | 144 ++++++++++++++
 tb/tb_axis_elastic_buf.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_elastic_buf.sv
// ---------------------------------------------------------------------------
// axis_elastic_buf
//   AXI-Stream style elastic buffer (synchronous FIFO) with occupancy output.
//   Full throughput: a push and a pop may happen on the same edge at any
//   level from 1 to DEPTH-1. tvalid_o and tready_o come only from registered
//   state, so there is no combinational path from tvalid_i or tready_i.
//
// Parameters
//   DATA_W  payload width in bits (1..64)
//   DEPTH   number of storage entries (power of two, 2..256)
//
// Ports
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset (priority over everything)
//   flush_i    synchronous discard of all stored beats
//   tvalid_i   upstream beat valid
//   tready_o   buffer can accept a beat (level != DEPTH)
//   tdata_i    upstream payload
//   tvalid_o   downstream beat available (level != 0)
//   tready_i   downstream accepts a beat
//   tdata_o    downstream payload (oldest stored entry)
//   tlast_i/o  per-beat last flag (only with AXIS_ELASTIC_BUF_TLAST_EN)
//   level_o    current occupancy, 0..DEPTH
//
// Optional build macro
//   AXIS_ELASTIC_BUF_TLAST_EN  adds tlast_i/tlast_o, stored alongside tdata.
// ---------------------------------------------------------------------------
module axis_elastic_buf #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              tvalid_i,
    output logic              tready_o,
    input  logic [DATA_W-1:0] tdata_i,
    output logic              tvalid_o,
    input  logic              tready_i,
    output logic [DATA_W-1:0] tdata_o,
`ifdef AXIS_ELASTIC_BUF_TLAST_EN
    input  logic              tlast_i,
    output logic              tlast_o,
`endif
    output logic [LVL_W-1:0]  level_o
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } occ_state_t;

    // Storage: no reset needed, contents are only read once written.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    occ_state_t        state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              push, pop;
    logic              head_from_input;

    // Handshake outputs decoded from the registered occupancy state only.
    assign tready_o = (state_q != ST_FULL);
    assign tvalid_o = (state_q != ST_EMPTY);
    assign tdata_o  = data_q;
    assign level_o  = level_q;

    always_comb begin
        push     = tvalid_i && tready_o;
        pop      = tvalid_o && tready_i;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        level_d  = level_q + LVL_W'(push) - LVL_W'(pop);

        // The beat being pushed becomes the head when nothing else remains
        // after this edge's pop; otherwise the next head is already stored.
        head_from_input = push && (level_q == LVL_W'(pop));
        data_d          = head_from_input ? tdata_i : mem[rd_ptr_d];

        if (level_d == '0) begin
            state_d = ST_EMPTY;
        end else if (level_d == LVL_W'(DEPTH)) begin
            state_d = ST_FULL;
        end else begin
            state_d = ST_PARTIAL;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            state_q  <= ST_EMPTY;
            data_q   <= '0;
        end else if (flush_i) begin
            // Head register is don't-care while empty, so it is left alone.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            state_q  <= ST_EMPTY;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            state_q  <= state_d;
            data_q   <= data_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !rst_i && !flush_i) begin
            mem[wr_ptr_q] <= tdata_i;
        end
    end

`ifdef AXIS_ELASTIC_BUF_TLAST_EN
    logic mem_last [DEPTH];
    logic last_q;

    assign tlast_o = last_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b0;
        end else if (!flush_i) begin
            last_q <= head_from_input ? tlast_i : mem_last[rd_ptr_d];
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !rst_i && !flush_i) begin
            mem_last[wr_ptr_q] <= tlast_i;
        end
    end
`endif

endmodule

// File: tb/tb_axis_elastic_buf.sv
// ---------------------------------------------------------------------------
// tb_axis_elastic_buf
//   Self-checking bench for axis_elastic_buf (DATA_W=8, DEPTH=4): a table of
//   directed vectors, a streaming sequence through pointer wrap, randomized
//   traffic against a queue model, and a tlast sequence in the tlast build.
// ---------------------------------------------------------------------------
module tb_axis_elastic_buf;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int LVL_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_i, flush_i, tvalid_i, tready_i;
    logic [DATA_W-1:0] tdata_i;
    logic              tready_o, tvalid_o;
    logic [DATA_W-1:0] tdata_o;
    logic [LVL_W-1:0]  level_o;
`ifdef AXIS_ELASTIC_BUF_TLAST_EN
    logic              tlast_i, tlast_o;
`endif

    int checks   = 0;
    int failures = 0;

    axis_elastic_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .flush_i  (flush_i),
        .tvalid_i (tvalid_i),
        .tready_o (tready_o),
        .tdata_i  (tdata_i),
        .tvalid_o (tvalid_o),
        .tready_i (tready_i),
        .tdata_o  (tdata_o),
`ifdef AXIS_ELASTIC_BUF_TLAST_EN
        .tlast_i  (tlast_i),
        .tlast_o  (tlast_o),
`endif
        .level_o  (level_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       flush;
        logic       vin;
        logic [7:0] din;
        logic       rin;
        int         e_lvl;
        logic       e_vld;
        logic       e_rdy;
        logic [7:0] e_dat;
        logic       chk_dat;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic flush, input logic vin,
                       input logic [7:0] din, input logic rin, input int e_lvl,
                       input logic e_vld, input logic e_rdy, input logic [7:0] e_dat,
                       input logic chk_dat);
        vec_t v;
        v.rst = rst; v.flush = flush; v.vin = vin; v.din = din; v.rin = rin;
        v.e_lvl = e_lvl; v.e_vld = e_vld; v.e_rdy = e_rdy; v.e_dat = e_dat;
        v.chk_dat = chk_dat;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs, clock one edge, settle just after it.
    task automatic step(input logic rst, input logic flush, input logic vin,
                        input logic [7:0] din, input logic rin);
        rst_i = rst; flush_i = flush; tvalid_i = vin; tdata_i = din; tready_i = rin;
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference: a queue of the beats held by the buffer.
    logic [7:0] model_q[$];

    task automatic model_edge(input logic rst, input logic flush, input logic vin,
                              input logic [7:0] din, input logic rin,
                              output logic did_push, output logic did_pop);
        did_push = vin && (model_q.size() < DEPTH);
        did_pop  = rin && (model_q.size() > 0);
        if (rst || flush) begin
            model_q.delete();
            did_push = 1'b0;
            did_pop  = 1'b0;
        end else begin
            if (did_pop) void'(model_q.pop_front());
            if (did_push) model_q.push_back(din);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".level"},  int'(level_o),  model_q.size());
        chk({tag, ".tvalid"}, int'(tvalid_o), int'(model_q.size() != 0));
        chk({tag, ".tready"}, int'(tready_o), int'(model_q.size() != DEPTH));
        if (model_q.size() != 0) chk({tag, ".tdata"}, int'(tdata_o), int'(model_q[0]));
    endtask

    initial begin
        logic p, q;

        rst_i = 1'b1; flush_i = 1'b0; tvalid_i = 1'b0; tready_i = 1'b0; tdata_i = '0;
`ifdef AXIS_ELASTIC_BUF_TLAST_EN
        tlast_i = 1'b0;
`endif

        //   rst flush vin din    rin  lvl vld rdy dat   chkdat
        add(1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h00, 1);   // reset values
        add(0, 0, 1, 8'hA5, 0, 1, 1, 1, 8'hA5, 1);   // single beat, 1-cycle latency
        add(0, 0, 0, 8'h00, 1, 0, 0, 1, 8'h00, 0);   // pop it
        add(0, 0, 1, 8'h01, 0, 1, 1, 1, 8'h01, 1);   // fill under backpressure
        add(0, 0, 1, 8'h02, 0, 2, 1, 1, 8'h01, 1);
        add(0, 0, 1, 8'h03, 0, 3, 1, 1, 8'h01, 1);
        add(0, 0, 1, 8'h04, 0, 4, 1, 0, 8'h01, 1);
        add(0, 0, 1, 8'h05, 0, 4, 1, 0, 8'h01, 1);   // 0x05 held upstream
        add(0, 0, 1, 8'h05, 1, 3, 1, 1, 8'h02, 1);   // full + both: pop only
        add(0, 0, 1, 8'h05, 1, 3, 1, 1, 8'h03, 1);   // 0x05 accepted now
        add(0, 0, 0, 8'h00, 1, 2, 1, 1, 8'h04, 1);
        add(0, 0, 0, 8'h00, 1, 1, 1, 1, 8'h05, 1);
        add(0, 0, 0, 8'h00, 1, 0, 0, 1, 8'h00, 0);
        add(0, 0, 1, 8'h30, 0, 1, 1, 1, 8'h30, 1);   // build level 3
        add(0, 0, 1, 8'h31, 0, 2, 1, 1, 8'h30, 1);
        add(0, 0, 1, 8'h32, 0, 3, 1, 1, 8'h30, 1);
        add(0, 1, 1, 8'h33, 1, 0, 0, 1, 8'h00, 0);   // flush discards push
        add(0, 0, 1, 8'h40, 0, 1, 1, 1, 8'h40, 1);   // post-flush push
        add(0, 0, 1, 8'h41, 0, 2, 1, 1, 8'h40, 1);
        add(1, 1, 1, 8'h42, 1, 0, 0, 1, 8'h00, 1);   // reset at level 2
        add(0, 0, 1, 8'h50, 0, 1, 1, 1, 8'h50, 1);   // push right after reset
        add(0, 0, 0, 8'h00, 1, 0, 0, 1, 8'h00, 0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].flush, vecs[i].vin, vecs[i].din, vecs[i].rin);
            $display("vec %0d: rst=%0d flush=%0d vin=%0d din=%02h rin=%0d -> lvl=%0d vld=%0d rdy=%0d dat=%02h",
                     i, vecs[i].rst, vecs[i].flush, vecs[i].vin, vecs[i].din, vecs[i].rin,
                     level_o, tvalid_o, tready_o, tdata_o);
            chk($sformatf("vec%0d.level", i),  int'(level_o),  vecs[i].e_lvl);
            chk($sformatf("vec%0d.tvalid", i), int'(tvalid_o), int'(vecs[i].e_vld));
            chk($sformatf("vec%0d.tready", i), int'(tready_o), int'(vecs[i].e_rdy));
            if (vecs[i].chk_dat)
                chk($sformatf("vec%0d.tdata", i), int'(tdata_o), int'(vecs[i].e_dat));
        end

        // Streaming through pointer wrap: every beat appears one cycle later.
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 1, 8'(i), 1);
            $display("stream %0d: lvl=%0d vld=%0d dat=%02h", i, level_o, tvalid_o, tdata_o);
            chk($sformatf("stream%0d.level", i),  int'(level_o),  1);
            chk($sformatf("stream%0d.tvalid", i), int'(tvalid_o), 1);
            chk($sformatf("stream%0d.tdata", i),  int'(tdata_o),  i);
        end
        step(0, 0, 0, 8'h00, 1);
        chk("stream.drain", int'(level_o), 0);

        // Randomized traffic against the queue model.
        step(1, 0, 0, 8'h00, 0);
        model_q.delete();
        for (int i = 0; i < 400; i++) begin
            logic       r_rst, r_flush, r_vin, r_rin;
            logic [7:0] r_din;
            r_rst   = ($urandom_range(0, 99) == 0);
            r_flush = ($urandom_range(0, 49) == 0);
            r_vin   = ($urandom_range(0, 3) != 0);
            r_rin   = ($urandom_range(0, 2) != 0);
            r_din   = 8'($urandom);
            model_edge(r_rst, r_flush, r_vin, r_din, r_rin, p, q);
            step(r_rst, r_flush, r_vin, r_din, r_rin);
            $display("rand %0d: rst=%0d flush=%0d push=%0d pop=%0d din=%02h lvl=%0d dat=%02h",
                     i, r_rst, r_flush, p, q, r_din, level_o, tdata_o);
            check_model($sformatf("rand%0d", i));
        end

`ifdef AXIS_ELASTIC_BUF_TLAST_EN
        step(1, 0, 0, 8'h00, 0);
        chk("tlast.reset", int'(tlast_o), 0);
        tlast_i = 1'b0;
        step(0, 0, 1, 8'h10, 0);
        tlast_i = 1'b1;
        step(0, 0, 1, 8'h11, 0);
        tlast_i = 1'b0;
        $display("tlast: head dat=%02h last=%0d", tdata_o, tlast_o);
        chk("tlast.beat0.tdata", int'(tdata_o), 8'h10);
        chk("tlast.beat0.tlast", int'(tlast_o), 0);
        step(0, 0, 0, 8'h00, 1);
        $display("tlast: head dat=%02h last=%0d", tdata_o, tlast_o);
        chk("tlast.beat1.tdata", int'(tdata_o), 8'h11);
        chk("tlast.beat1.tlast", int'(tlast_o), 1);
        step(0, 0, 0, 8'h00, 1);
        chk("tlast.drain", int'(level_o), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
